// File: rtl/can_rx_if.sv
// ============================================================================
//  Module      : can_rx_if
//  Description : Bus-side and decoded-frame signal bundle for the CAN receiver.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface can_rx_if;
    logic        rx;
    logic        sample_en;
    logic        ack_tx;
    logic        rxing;
    logic [10:0] address;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        frame_valid;
    logic        rx_error;
    logic [1:0]  err_code;

    modport master (
        input  rx, sample_en,
        output ack_tx, rxing, address, rtr, dlc, data, frame_valid, rx_error, err_code
    );

    modport slave (
        output rx, sample_en,
        input  ack_tx, rxing, address, rtr, dlc, data, frame_valid, rx_error, err_code
    );
endinterface

`default_nettype wire

// File: rtl/can_rx.sv
// ============================================================================
//  Module      : can_rx
//  Description : CAN 2.0A standard-frame receiver with destuffing, CRC-15
//                check, ACK slot drive and decoded-frame presentation.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module can_rx #(
    parameter int IDLE_BITS = 11,
    parameter int MAX_BYTES = 8
) (
    input  logic     clk,
    input  logic     rst,
    can_rx_if.master bus
);

    localparam int              c_idle_w    = (IDLE_BITS > 2) ? $clog2(IDLE_BITS) : 1;
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_BITS - 1);
    localparam logic [3:0]      c_max_bytes = 4'(MAX_BYTES);
    localparam logic [14:0]     c_crc_poly  = 15'h4599;

    localparam logic [1:0] c_err_stuff = 2'd1;
    localparam logic [1:0] c_err_form  = 2'd2;
    localparam logic [1:0] c_err_crc   = 2'd3;

    localparam logic [3:0] c_st_wait_idle = 4'd0;
    localparam logic [3:0] c_st_idle      = 4'd1;
    localparam logic [3:0] c_st_id        = 4'd2;
    localparam logic [3:0] c_st_rtr       = 4'd3;
    localparam logic [3:0] c_st_ide       = 4'd4;
    localparam logic [3:0] c_st_r0        = 4'd5;
    localparam logic [3:0] c_st_dlc       = 4'd6;
    localparam logic [3:0] c_st_data      = 4'd7;
    localparam logic [3:0] c_st_crc       = 4'd8;
    localparam logic [3:0] c_st_crc_del   = 4'd9;
    localparam logic [3:0] c_st_ack       = 4'd10;
    localparam logic [3:0] c_st_ack_del   = 4'd11;
    localparam logic [3:0] c_st_eof       = 4'd12;

    logic [3:0]          r_state;
    logic [c_idle_w-1:0] r_idle_cnt;
    logic [6:0]          r_cnt;
    logic [2:0]          r_run;
    logic                r_last;
    logic [14:0]         r_crc;
    logic [13:0]         r_crc_rx;
    logic                r_crc_ok;
    logic [10:0]         r_id_sh;
    logic                r_rtr_sh;
    logic [3:0]          r_dlc_sh;
    logic [3:0]          r_nbytes;
    logic [63:0]         r_data_sh;

    logic                r_ack_tx;
    logic                r_rxing;
    logic [10:0]         r_address;
    logic                r_rtr;
    logic [3:0]          r_dlc;
    logic [63:0]         r_data;
    logic                r_frame_valid;
    logic                r_rx_error;
    logic [1:0]          r_err_code;

    logic                w_in_window;
    logic                w_stuff;
    logic                w_stuff_err;
    logic                w_crc_fb;
    logic [14:0]         w_crc_upd;
    logic [3:0]          w_dlc_full;
    logic [3:0]          w_nbytes;
    logic [14:0]         w_crc_rx_full;
    logic                w_err;
    logic [1:0]          w_err_code;

    // Stuff bits exist only from SOF through the last CRC bit.
    assign w_in_window   = (r_state >= c_st_id) && (r_state <= c_st_crc);
    assign w_stuff       = w_in_window && (r_run == 3'd5);
    assign w_stuff_err   = w_stuff && (bus.rx == r_last);
    assign w_crc_fb      = bus.rx ^ r_crc[14];
    assign w_crc_upd     = {r_crc[13:0], 1'b0} ^ (w_crc_fb ? c_crc_poly : 15'd0);
    assign w_dlc_full    = {r_dlc_sh[2:0], bus.rx};
    assign w_nbytes      = (w_dlc_full > c_max_bytes) ? c_max_bytes : w_dlc_full;
    assign w_crc_rx_full = {r_crc_rx, bus.rx};

    always_comb begin
        w_err      = 1'b0;
        w_err_code = 2'd0;
        if (bus.sample_en) begin
            if (w_stuff_err) begin
                w_err      = 1'b1;
                w_err_code = c_err_stuff;
            end else if (!w_stuff) begin
                case (r_state)
                    c_st_ide: begin
                        if (bus.rx) begin
                            w_err      = 1'b1;
                            w_err_code = c_err_form;
                        end
                    end
                    c_st_crc_del: begin
                        if (!r_crc_ok) begin
                            w_err      = 1'b1;
                            w_err_code = c_err_crc;
                        end else if (!bus.rx) begin
                            w_err      = 1'b1;
                            w_err_code = c_err_form;
                        end
                    end
                    c_st_ack_del, c_st_eof: begin
                        if (!bus.rx) begin
                            w_err      = 1'b1;
                            w_err_code = c_err_form;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_wait_idle;
            r_idle_cnt    <= '0;
            r_cnt         <= '0;
            r_run         <= '0;
            r_last        <= 1'b1;
            r_crc         <= '0;
            r_crc_rx      <= '0;
            r_crc_ok      <= 1'b0;
            r_id_sh       <= '0;
            r_rtr_sh      <= 1'b0;
            r_dlc_sh      <= '0;
            r_nbytes      <= '0;
            r_data_sh     <= '0;
            r_ack_tx      <= 1'b1;
            r_rxing       <= 1'b0;
            r_address     <= '0;
            r_rtr         <= 1'b0;
            r_dlc         <= '0;
            r_data        <= '0;
            r_frame_valid <= 1'b0;
            r_rx_error    <= 1'b0;
            r_err_code    <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_rx_error    <= 1'b0;
            if (bus.sample_en) begin
                if (w_in_window) begin
                    if (w_stuff || (bus.rx != r_last)) begin
                        r_run  <= 3'd1;
                        r_last <= bus.rx;
                    end else begin
                        r_run <= r_run + 3'd1;
                    end
                end
                if (w_err) begin
                    r_rx_error <= 1'b1;
                    r_err_code <= w_err_code;
                    r_ack_tx   <= 1'b1;
                    r_rxing    <= 1'b0;
                    r_idle_cnt <= '0;
                    r_state    <= c_st_wait_idle;
                end else if (!w_stuff) begin
                    case (r_state)
                        c_st_wait_idle: begin
                            if (!bus.rx) begin
                                r_idle_cnt <= '0;
                            end else if (r_idle_cnt == c_idle_last) begin
                                r_idle_cnt <= '0;
                                r_state    <= c_st_idle;
                            end else begin
                                r_idle_cnt <= r_idle_cnt + 1'b1;
                            end
                        end
                        c_st_idle: begin
                            if (!bus.rx) begin
                                // SOF is the first bit of the stuffed run; CRC of a lone 0 stays 0.
                                r_crc     <= '0;
                                r_run     <= 3'd1;
                                r_last    <= 1'b0;
                                r_cnt     <= '0;
                                r_crc_ok  <= 1'b0;
                                r_id_sh   <= '0;
                                r_rtr_sh  <= 1'b0;
                                r_dlc_sh  <= '0;
                                r_data_sh <= '0;
                                r_rxing   <= 1'b1;
                                r_state   <= c_st_id;
                            end
                        end
                        c_st_id: begin
                            r_id_sh <= {r_id_sh[9:0], bus.rx};
                            r_crc   <= w_crc_upd;
                            if (r_cnt == 7'd10) begin
                                r_cnt   <= '0;
                                r_state <= c_st_rtr;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        c_st_rtr: begin
                            r_rtr_sh <= bus.rx;
                            r_crc    <= w_crc_upd;
                            r_state  <= c_st_ide;
                        end
                        c_st_ide: begin
                            r_crc   <= w_crc_upd;
                            r_state <= c_st_r0;
                        end
                        c_st_r0: begin
                            r_crc   <= w_crc_upd;
                            r_cnt   <= '0;
                            r_state <= c_st_dlc;
                        end
                        c_st_dlc: begin
                            r_dlc_sh <= w_dlc_full;
                            r_crc    <= w_crc_upd;
                            if (r_cnt == 7'd3) begin
                                r_nbytes <= w_nbytes;
                                r_cnt    <= '0;
                                r_state  <= (r_rtr_sh || (w_nbytes == 4'd0)) ? c_st_crc : c_st_data;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        c_st_data: begin
                            // First received bit lands in data[63]; ~cnt walks downward.
                            r_data_sh[~r_cnt[5:0]] <= bus.rx;
                            r_crc                  <= w_crc_upd;
                            if (r_cnt == ({r_nbytes, 3'b000} - 7'd1)) begin
                                r_cnt   <= '0;
                                r_state <= c_st_crc;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        c_st_crc: begin
                            r_crc_rx <= w_crc_rx_full[13:0];
                            if (r_cnt == 7'd14) begin
                                r_crc_ok <= (w_crc_rx_full == r_crc);
                                r_cnt    <= '0;
                                r_state  <= c_st_crc_del;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        c_st_crc_del: begin
                            r_ack_tx <= 1'b0;
                            r_state  <= c_st_ack;
                        end
                        c_st_ack: begin
                            r_ack_tx <= 1'b1;
                            r_state  <= c_st_ack_del;
                        end
                        c_st_ack_del: begin
                            r_cnt   <= '0;
                            r_state <= c_st_eof;
                        end
                        c_st_eof: begin
                            if (r_cnt == 7'd6) begin
                                r_frame_valid <= 1'b1;
                                r_rxing       <= 1'b0;
                                r_address     <= r_id_sh;
                                r_rtr         <= r_rtr_sh;
                                r_dlc         <= r_dlc_sh;
                                r_data        <= r_data_sh;
                                r_cnt         <= '0;
                                r_state       <= c_st_idle;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                        default: r_state <= c_st_wait_idle;
                    endcase
                end
            end
        end
    end

    assign bus.ack_tx      = r_ack_tx;
    assign bus.rxing       = r_rxing;
    assign bus.address     = r_address;
    assign bus.rtr         = r_rtr;
    assign bus.dlc         = r_dlc;
    assign bus.data        = r_data;
    assign bus.frame_valid = r_frame_valid;
    assign bus.rx_error    = r_rx_error;
    assign bus.err_code    = r_err_code;

endmodule

`default_nettype wire
